// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA coordinate defaults, arbiter state encodings and onehot helper
package vga_pkg;
  localparam int X_W_DEF = 10;
  localparam int Y_W_DEF = 9;
  localparam int COLOR_W_DEF = 9;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_OWNED = 1'b1} arb_state_t;
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) onehot_to_idx = 3'(i);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder, searching from last+1 mod N
module rr_pick
  import vga_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] p;
  assign valid = |req;
  // walk from the lowest priority up so the nearest candidate after last wins
  always_comb begin
    idx = '0;
    p = '0;
    for (int k = N; k >= 1; k--) begin
      p = IW'((int'(last) + k) % N);
      idx = req[p] ? p : idx;
    end
  end
endmodule

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin owner of the single vga_adapter pixel port.
// Define PIXEL_ARB_QUANTUM_EN to preempt an owner after QUANTUM cycles when others wait.
module pixel_write_arbiter
  import vga_pkg::*;
#(
  parameter int N = 4,
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int QUANTUM = 256
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*X_W-1:0]     in_x,
  input  logic [N*Y_W-1:0]     in_y,
  input  logic [N*COLOR_W-1:0] in_color,
  input  logic [N-1:0]         in_write,
  output logic [N-1:0]         gnt,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [COLOR_W-1:0]   vga_color,
  output logic                 vga_write,
  output logic                 busy,
  output logic                 drop_err
);
  localparam int IW = $clog2(N);
  arb_state_t state, state_n;
  logic [N-1:0] gnt_n;
  logic [IW-1:0] last, last_n, o, pidx;
  logic pv, expire, handoff;
  assign o = IW'(onehot_to_idx(8'(gnt)));
  // the current owner is never a candidate, so a revoke always moves on
  rr_pick #(.N(N)) u_pick (.req(req & ~gnt), .last(last), .valid(pv), .idx(pidx));
`ifdef PIXEL_ARB_QUANTUM_EN
  localparam int CW = $clog2(QUANTUM);
  logic [CW-1:0] cnt;
  assign expire = cnt == CW'(QUANTUM - 1);
  always_ff @(posedge clk)
    cnt <= (reset || (handoff && pv)) ? '0 : (state == ARB_OWNED && !expire) ? cnt + 1'b1 : cnt;
`else
  assign expire = 1'b0;
`endif
  assign handoff = state == ARB_IDLE || !req[o] || (expire && pv);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      gnt <= '0;
      last <= IW'(N - 1);
      vga_x <= '0;
      vga_y <= '0;
      vga_color <= '0;
      vga_write <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      last <= last_n;
      vga_write <= in_write[o] & gnt[o];
      if (|gnt) begin
        vga_x <= in_x[int'(o)*X_W +: X_W];
        vga_y <= in_y[int'(o)*Y_W +: Y_W];
        vga_color <= in_color[int'(o)*COLOR_W +: COLOR_W];
      end
      drop_err <= drop_err | |(in_write & ~gnt);
    end
  end
  always_comb begin
    state_n = handoff ? (pv ? ARB_OWNED : ARB_IDLE) : state;
    gnt_n = handoff ? (pv ? N'(1) << pidx : '0) : gnt;
    last_n = (handoff && pv) ? pidx : last;
  end
  always_comb busy = state == ARB_OWNED;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter: scenario tasks plus a per-cycle scoreboard fed by a reference model
module tb_pixel_write_arbiter;
  localparam int Q = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [39:0] in_x = '0;
  logic [35:0] in_y = '0;
  logic [35:0] in_color = '0;
  logic [3:0] in_write = '0;
  logic [3:0] gnt;
  logic [9:0] vga_x;
  logic [8:0] vga_y, vga_color;
  logic vga_write, busy, drop_err;
  int n_vec = 0, n_err = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic w;
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] c;
    logic busy;
    logic drop;
  } exp_t;
  exp_t sb[$];

  logic [3:0] m_gnt;
  int m_last, m_cnt;
  logic m_w, m_drop;
  logic [9:0] m_x;
  logic [8:0] m_y, m_c;

  pixel_write_arbiter #(.N(4), .X_W(10), .Y_W(9), .COLOR_W(9), .QUANTUM(Q)) dut (
    .clk(clk), .reset(reset), .req(req), .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .in_write(in_write), .gnt(gnt), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .vga_write(vga_write), .busy(busy), .drop_err(drop_err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (gnt !== e.gnt) begin n_err++; $display("FAIL sb_gnt: got %b expected %b", gnt, e.gnt); end
      if (vga_write !== e.w) begin n_err++; $display("FAIL sb_write: got %b expected %b", vga_write, e.w); end
      if (vga_x !== e.x) begin n_err++; $display("FAIL sb_x: got %0d expected %0d", vga_x, e.x); end
      if (vga_y !== e.y) begin n_err++; $display("FAIL sb_y: got %0d expected %0d", vga_y, e.y); end
      if (vga_color !== e.c) begin n_err++; $display("FAIL sb_color: got %h expected %h", vga_color, e.c); end
      if (busy !== e.busy) begin n_err++; $display("FAIL sb_busy: got %b expected %b", busy, e.busy); end
      if (drop_err !== e.drop) begin n_err++; $display("FAIL sb_drop: got %b expected %b", drop_err, e.drop); end
    end
  end

  // advance the reference model over the coming edge, queue its prediction, then clock
  task automatic tick();
    int mo, pick;
    logic [3:0] others;
    logic hand;
    if (reset) begin
      m_gnt = '0; m_last = 3; m_cnt = 0; m_w = 1'b0; m_drop = 1'b0;
      m_x = '0; m_y = '0; m_c = '0;
    end else begin
      mo = 0;
      for (int i = 0; i < 4; i++) if (m_gnt[i]) mo = i;
      m_w = (m_gnt != 0) && in_write[mo];
      if (m_gnt != 0) begin
        m_x = in_x[mo*10 +: 10];
        m_y = in_y[mo*9 +: 9];
        m_c = in_color[mo*9 +: 9];
      end
      m_drop = m_drop | (|(in_write & ~m_gnt));
      others = req & ~m_gnt;
      hand = (m_gnt == 0) || !req[mo];
`ifdef PIXEL_ARB_QUANTUM_EN
      hand = hand || (m_cnt == Q - 1 && others != 0);
`endif
      if (hand) begin
        pick = -1;
        for (int k = 1; k <= 4; k++)
          if (pick < 0 && others[(m_last + k) % 4]) pick = (m_last + k) % 4;
        m_gnt = (pick < 0) ? 4'b0 : 4'(1 << pick);
        if (pick >= 0) m_last = pick;
        m_cnt = 0;
      end else if (m_cnt < Q - 1) m_cnt++;
    end
    sb.push_back({m_gnt, m_w, m_x, m_y, m_c, m_gnt != 0, m_drop});
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input logic w, input logic [9:0] x, input logic [8:0] y, input logic [8:0] c);
    in_write[i] = w;
    in_x[i*10 +: 10] = x;
    in_y[i*9 +: 9] = y;
    in_color[i*9 +: 9] = c;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; in_write = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) begin
      tick();
      n_vec++;
      if (gnt !== 4'b0 || vga_write !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle: gnt=%b write=%b busy=%b required 0000/0/0", gnt, vga_write, busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b required 0001", gnt); end
    set_px(0, 1'b1, 10'd5, 9'd7, 9'h1FF);
    tick();
    n_vec++;
    if (vga_write !== 1'b1 || vga_x !== 10'd5 || vga_y !== 9'd7 || vga_color !== 9'h1FF) begin
      n_err++;
      $display("FAIL single_pixel: w=%b x=%0d y=%0d c=%h required 1/5/7/1ff", vga_write, vga_x, vga_y, vga_color);
    end
    in_write = '0; req = '0;
    tick();
    n_vec++;
    if (gnt !== 4'b0 || busy !== 1'b0 || vga_write !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: gnt=%b busy=%b w=%b required 0000/0/0", gnt, busy, vga_write);
    end
  endtask

  task automatic test_rotation();
    int wc[4];
    do_reset();
    wc = '{0, 0, 0, 0};
    req = 4'b1111;
    for (int k = 0; k < 14; k++) begin
      in_write = '0;
      for (int i = 0; i < 4; i++)
        if (gnt[i]) begin
          set_px(i, 1'b1, 10'($urandom), 9'($urandom), 9'($urandom));
          wc[i]++;
          if (wc[i] == 3) req[i] = 1'b0;
        end
      tick();
      n_vec++;
      if (gnt !== ((k < 12) ? 4'(1 << (k / 3)) : 4'b0)) begin
        n_err++;
        $display("FAIL rotation_gnt[%0d]: got %b required %b", k, gnt, (k < 12) ? 4'(1 << (k / 3)) : 4'b0);
      end
    end
    in_write = '0;
  endtask

  task automatic test_handoff();
    do_reset();
    req = 4'b0001;
    tick();
    set_px(0, 1'b1, 10'd300, 9'd200, 9'h0AA);
    req = 4'b0101;
    repeat (2) begin
      tick();
      n_vec++;
      if (gnt !== 4'b0001) begin n_err++; $display("FAIL handoff_hold: got %b required 0001", gnt); end
    end
    req = 4'b0100;
    tick();
    n_vec++;
    if (gnt !== 4'b0100) begin n_err++; $display("FAIL handoff_next: got %b required 0100", gnt); end
    in_write = '0;
    set_px(2, 1'b1, 10'd639, 9'd479, 9'h155);
    req = 4'b0101;
    repeat (3) begin
      tick();
      n_vec++;
      if (gnt !== 4'b0100) begin n_err++; $display("FAIL handoff_wait: got %b required 0100", gnt); end
    end
    in_write = '0;
    req = 4'b0001;
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL handoff_back: got %b required 0001", gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0001;
    tick();
    n_vec++;
    if (drop_err !== 1'b0) begin n_err++; $display("FAIL drop_clear: got %b required 0", drop_err); end
    set_px(0, 1'b1, 10'd11, 9'd22, 9'd33);
    set_px(3, 1'b1, 10'd600, 9'd400, 9'd1);
    tick();
    n_vec++;
    if (vga_write !== 1'b1 || vga_x !== 10'd11 || drop_err !== 1'b1) begin
      n_err++;
      $display("FAIL drop_owner: w=%b x=%0d drop=%b required 1/11/1", vga_write, vga_x, drop_err);
    end
    in_write = '0; req = '0;
    repeat (3) begin
      tick();
      n_vec++;
      if (drop_err !== 1'b1) begin n_err++; $display("FAIL drop_sticky: got %b required 1", drop_err); end
    end
    do_reset();
    n_vec++;
    if (drop_err !== 1'b0) begin n_err++; $display("FAIL drop_reset: got %b required 0", drop_err); end
  endtask

  task automatic test_quantum();
    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 16; k++) begin
      set_px(0, gnt[0], 10'(k), 9'(k + 1), 9'(k + 2));
      tick();
      n_vec++;
`ifdef PIXEL_ARB_QUANTUM_EN
      if (gnt !== (((k / Q) % 2) ? 4'b0010 : 4'b0001)) begin
        n_err++;
        $display("FAIL quantum_gnt[%0d]: got %b required %b", k, gnt, ((k / Q) % 2) ? 4'b0010 : 4'b0001);
      end
`else
      if (gnt !== 4'b0001) begin n_err++; $display("FAIL hold_gnt[%0d]: got %b required 0001", k, gnt); end
`endif
    end
    in_write = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (gnt !== 4'b0 || busy !== 1'b0 || vga_write !== 1'b0 || vga_x !== 10'd0 || drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL midpass_reset: gnt=%b busy=%b w=%b x=%0d drop=%b required all zero", gnt, busy, vga_write, vga_x, drop_err);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_handoff();
    test_drop();
    test_quantum();
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d predictions left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
